// File: rtl/dispatch_sysreg_write_buffer.sv
// In-order write buffer for speculative system-register writes: entries retire on commit and are dropped on flush.
// Optional youngest-entry forwarding is enabled by defining MIST1032ISA_SYSREG_WB_FORWARD_EN.
module dispatch_sysreg_write_buffer #(
  parameter int P_DEPTH = 4
) (
  input  logic                         iCLOCK,
  input  logic                         inRESET,
  input  logic                         iRESET_SYNC,
  input  logic                         iWR_REQ,
  input  logic [31:0]                  iWR_DATA,
  output logic                         oWR_BUSY,
  input  logic                         iCOMMIT,
  input  logic                         iFLUSH,
  output logic                         oREGIST_DATA_VALID,
  output logic [31:0]                  oREGIST_DATA,
  output logic [$clog2(P_DEPTH):0]     oCOUNT,
  output logic                         oEMPTY,
  output logic                         oFWD_VALID,
  output logic [31:0]                  oFWD_DATA
);

  localparam int PW = $clog2(P_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_mem [P_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic [31:0]   r_data;

  logic w_busy;
  logic w_empty;
  logic w_wr_ok;
  logic w_cmt_ok;
  logic w_store;

  assign w_busy   = (r_count == CW'(P_DEPTH));
  assign w_empty  = (r_count == '0);
  // Busy comes from the registered count, so a same-cycle commit never makes room.
  assign w_wr_ok  = iWR_REQ && !w_busy;
  assign w_cmt_ok = iCOMMIT && !w_empty;
  assign w_store  = w_wr_ok && !iFLUSH && !iRESET_SYNC;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_data  <= 32'h0;
    end else if (iRESET_SYNC) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_data  <= 32'h0;
    end else begin
      r_valid <= w_cmt_ok;
      if (w_cmt_ok) begin
        r_data <= r_mem[r_rptr];
      end
      // Flush drops everything still pending, including the same-cycle write;
      // a same-cycle commit has already captured the oldest entry above.
      if (iFLUSH) begin
        r_count <= '0;
        r_rptr  <= r_wptr;
      end else begin
        if (w_wr_ok) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_cmt_ok) begin
          r_rptr <= r_rptr + 1'b1;
        end
        r_count <= r_count + CW'(w_wr_ok) - CW'(w_cmt_ok);
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_store) begin
      r_mem[r_wptr] <= iWR_DATA;
    end
  end

  assign oWR_BUSY           = w_busy;
  assign oREGIST_DATA_VALID = r_valid;
  assign oREGIST_DATA       = r_data;
  assign oCOUNT             = r_count;
  assign oEMPTY             = w_empty;

`ifdef MIST1032ISA_SYSREG_WB_FORWARD_EN
  logic [PW-1:0] w_fwd_idx;
  assign w_fwd_idx  = r_wptr - 1'b1;
  assign oFWD_VALID = !w_empty;
  assign oFWD_DATA  = w_empty ? 32'h0 : r_mem[w_fwd_idx];
`else
  assign oFWD_VALID = 1'b0;
  assign oFWD_DATA  = 32'h0;
`endif

endmodule

// File: tb/tb_dispatch_sysreg_write_buffer.sv
// Scoreboard bench for dispatch_sysreg_write_buffer: stimulus pushes expected retire strobes,
// a negedge monitor pops and compares them; status outputs are checked directly.
module tb_dispatch_sysreg_write_buffer;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iWR_REQ = 1'b0;
  logic [31:0] iWR_DATA = 32'h0;
  logic        oWR_BUSY;
  logic        iCOMMIT = 1'b0;
  logic        iFLUSH = 1'b0;
  logic        oREGIST_DATA_VALID;
  logic [31:0] oREGIST_DATA;
  logic [2:0]  oCOUNT;
  logic        oEMPTY;
  logic        oFWD_VALID;
  logic [31:0] oFWD_DATA;

  dispatch_sysreg_write_buffer #(.P_DEPTH(4)) dut (
    .iCLOCK(iCLOCK),
    .inRESET(inRESET),
    .iRESET_SYNC(iRESET_SYNC),
    .iWR_REQ(iWR_REQ),
    .iWR_DATA(iWR_DATA),
    .oWR_BUSY(oWR_BUSY),
    .iCOMMIT(iCOMMIT),
    .iFLUSH(iFLUSH),
    .oREGIST_DATA_VALID(oREGIST_DATA_VALID),
    .oREGIST_DATA(oREGIST_DATA),
    .oCOUNT(oCOUNT),
    .oEMPTY(oEMPTY),
    .oFWD_VALID(oFWD_VALID),
    .oFWD_DATA(oFWD_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  always @(posedge iCLOCK) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, in the expected cycle.
  always @(negedge iCLOCK) begin
    if (inRESET && oREGIST_DATA_VALID) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %h expected no strobe", oREGIST_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_data", oREGIST_DATA, e.data);
        chk("strobe_cycle", cyc_cnt, e.cyc);
      end
    end
  end

  task automatic step(input logic wr, input logic [31:0] d, input logic cmt,
                      input logic fl, input logic rs, input logic push,
                      input logic [31:0] pv);
    exp_t e;
    iWR_REQ = wr; iWR_DATA = d; iCOMMIT = cmt; iFLUSH = fl; iRESET_SYNC = rs;
    if (push) begin
      e.data = pv;
      e.cyc  = cyc_cnt + 1;
      exp_q.push_back(e);
    end
    @(posedge iCLOCK);
    #1;
    iWR_REQ = 1'b0; iWR_DATA = 32'h0; iCOMMIT = 1'b0; iFLUSH = 1'b0; iRESET_SYNC = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic cmt(input logic push, input logic [31:0] pv);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, push, pv);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge iCLOCK);
    #1;
    chk("rst_empty", oEMPTY, 1);
    chk("rst_busy", oWR_BUSY, 0);
    chk("rst_count", oCOUNT, 0);
    chk("rst_valid", oREGIST_DATA_VALID, 0);
    chk("rst_data", oREGIST_DATA, 0);
    chk("rst_fwd_valid", oFWD_VALID, 0);
    inRESET = 1'b1;
    idle();

    // Fill, then overflow attempt
    wr(32'h11); wr(32'h22); wr(32'h33);
    chk("busy_at_3", oWR_BUSY, 0);
    wr(32'h44);
    chk("busy_at_4", oWR_BUSY, 1);
    wr(32'h55);
    chk("count_full", oCOUNT, 4);

    // Drain in order
    cmt(1, 32'h11); cmt(1, 32'h22); cmt(1, 32'h33); cmt(1, 32'h44);
    idle();
    chk("drain_empty", oEMPTY, 1);
    chk("data_hold", oREGIST_DATA, 32'h44);
    cmt(0, 32'h0);
    idle();
    chk("cmt_empty_count", oCOUNT, 0);

    // Full buffer: write + commit same cycle drops the write
    wr(32'h11); wr(32'h22); wr(32'h33); wr(32'h44);
    step(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11);
    chk("full_wc_count", oCOUNT, 3);
    cmt(1, 32'h22); cmt(1, 32'h33); cmt(1, 32'h44);
    chk("full_wc_empty", oEMPTY, 1);

    // Write + commit on empty
    step(1'b1, 32'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("empty_wc_count", oCOUNT, 1);
    cmt(1, 32'h5A);

    // Simultaneous write and commit with entries pending
    wr(32'h1); wr(32'h2);
    step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1);
    chk("wc_count", oCOUNT, 2);
    cmt(1, 32'h2); cmt(1, 32'h3);
    chk("wc_empty", oEMPTY, 1);

    // Flush + commit
    wr(32'hA); wr(32'hB);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA);
    chk("flush_cmt_count", oCOUNT, 0);
    cmt(0, 32'h0); cmt(0, 32'h0);
    chk("flush_after_count", oCOUNT, 0);

    // Flush + write drops the write; pointers stay coherent
    wr(32'hC1);
    step(1'b1, 32'hC2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("flush_wr_count", oCOUNT, 0);
    cmt(0, 32'h0);
    wr(32'hD1);
    cmt(1, 32'hD1);

    // Forwarding
    wr(32'hDEAD); wr(32'hBEEF);
`ifdef MIST1032ISA_SYSREG_WB_FORWARD_EN
    chk("fwd_valid", oFWD_VALID, 1);
    chk("fwd_data", oFWD_DATA, 32'hBEEF);
`else
    chk("fwd_valid", oFWD_VALID, 0);
    chk("fwd_data", oFWD_DATA, 32'h0);
`endif
    cmt(1, 32'hDEAD); cmt(1, 32'hBEEF);
    idle();

    // Sync reset overrides commit
    wr(32'h7);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("sync_count", oCOUNT, 0);
    chk("sync_data", oREGIST_DATA, 0);
    chk("sync_valid", oREGIST_DATA_VALID, 0);
    chk("sync_empty", oEMPTY, 1);

    // Async reset mid-operation
    wr(32'h61); wr(32'h62);
    cmt(1, 32'h61);
    idle();
    chk("pre_async_count", oCOUNT, 1);
    #1 inRESET = 1'b0;
    #1;
    chk("async_count", oCOUNT, 0);
    chk("async_empty", oEMPTY, 1);
    chk("async_data", oREGIST_DATA, 0);
    chk("async_busy", oWR_BUSY, 0);
    @(posedge iCLOCK);
    #1 inRESET = 1'b1;
    wr(32'h71);
    cmt(1, 32'h71);
    idle(); idle();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
